// File: rtl/updown_step_ctrl_if.sv
// Button/counter bundle for the up/down step controller.
// The board side (buttons plus counter read-back) uses the master modport.
// The controller uses the slave modport.
interface updown_step_ctrl_if;
    logic       btn_start;
    logic       btn_dir;
    logic       btn_clr;
    logic [3:0] count;
    logic       step;
    logic       dec;
    logic       clr_n;
    logic       run_led;

    modport master (
        output btn_start, btn_dir, btn_clr, count,
        input  step, dec, clr_n, run_led
    );

    modport slave (
        input  btn_start, btn_dir, btn_clr, count,
        output step, dec, clr_n, run_led
    );
endinterface

// File: rtl/updown_step_ctrl.sv
// Run/pause/direction sequencer for the single-digit up/down counter.
//
// Three async push buttons are synchronised and debounced. Each accepted
// rising level becomes a one-cycle press pulse. A prescaler times the step
// tick. The controller drives the counter's step enable, direction and clear.
//
// Optional feature: define UPDOWN_BOUNCE_EN to make the direction reverse at
// the count limits. When this is enabled, the counter bounces instead of
// wrapping. When it is not defined, COUNT is ignored.
module updown_step_ctrl #(
    parameter int unsigned TICK_MAX  = 6000000,
    parameter int unsigned DEB_MAX   = 60000,
    parameter logic [3:0]  COUNT_MAX = 4'h9
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    updown_step_ctrl_if.slave  bus_if
);

    localparam int unsigned PW = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam int unsigned DW = (DEB_MAX > 1) ? $clog2(DEB_MAX) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_MAX - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_MAX - 1);

    // Button lanes: bit 0 = start, bit 1 = dir, bit 2 = clr.
    localparam int unsigned B_START = 0;
    localparam int unsigned B_DIR   = 1;
    localparam int unsigned B_CLR   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // Button synchronisers and debouncers
    // ------------------------------------------------------------------
    logic [2:0]    btn_raw_s;
    logic [2:0]    sync1_q, sync1_d;
    logic [2:0]    sync2_q, sync2_d;
    logic [2:0]    level_q, level_d;
    logic [2:0]    prev_q,  prev_d;
    logic [DW-1:0] deb_cnt_q [3];
    logic [DW-1:0] deb_cnt_d [3];
    logic          start_press_s;
    logic          dir_press_s;
    logic          clr_press_s;

    assign btn_raw_s = {bus_if.btn_clr, bus_if.btn_dir, bus_if.btn_start};

    // A lane's accepted level changes only after DEB_MAX consecutive differing samples.
    always_comb begin
        sync1_d = btn_raw_s;
        sync2_d = sync1_q;
        prev_d  = level_q;
        level_d = level_q;
        for (int i = 0; i < 3; i++) begin
            deb_cnt_d[i] = {DW{1'b0}};
            if (sync2_q[i] != level_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    level_d[i]   = sync2_q[i];
                    deb_cnt_d[i] = {DW{1'b0}};
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end else begin
                deb_cnt_d[i] = {DW{1'b0}};
            end
        end
    end

    // Synchroniser, stability counter and accepted-level registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            level_q <= 3'b000;
            prev_q  <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= {DW{1'b0}};
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    // Press pulses are high for the single cycle after an accepted rising level.
    assign start_press_s = level_q[B_START] & ~prev_q[B_START];
    assign dir_press_s   = level_q[B_DIR]   & ~prev_q[B_DIR];
    assign clr_press_s   = level_q[B_CLR]   & ~prev_q[B_CLR];

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          dir_q,   dir_d;      // 1 = up
    logic          step_q,  step_d;
    logic          dec_q,   dec_d;
    logic          clr_n_q, clr_n_d;
    logic          run_led_q, run_led_d;
    logic          tick_s;
    logic          flip_s;

`ifdef UPDOWN_BOUNCE_EN
    // Counter is sitting at the limit it is heading towards.
    function automatic logic bounce_hit(input logic dir_up, input logic [3:0] cnt);
        bounce_hit = (dir_up && (cnt == COUNT_MAX)) || (!dir_up && (cnt == 4'h0));
    endfunction

    // Reverse direction at a limit on a tick so that STEP moves away from the limit.
    always_comb begin
        flip_s = tick_s && !clr_press_s && bounce_hit(dir_q, bus_if.count);
    end
`else
    logic unused_count_s;
    assign unused_count_s = ^{bus_if.count, COUNT_MAX};

    // Without bounce the direction only follows the button and clear.
    always_comb begin
        flip_s = 1'b0;
    end
`endif

    assign tick_s = (state_q == ST_RUN) && (presc_q == TICK_LAST);

    // Next state, prescaler, direction and output values.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        dir_d     = dir_q;
        dec_d     = dir_q;
        step_d    = 1'b0;
        clr_n_d   = 1'b1;
        run_led_d = 1'b0;

        // Clear outranks start; start and dir may act together.
        if (clr_press_s) begin
            state_d = ST_CLEAR;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_press_s) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (start_press_s) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (start_press_s) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_CLEAR: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Prescaler runs in RUN, keeps its phase in PAUSE, and is zeroed otherwise.
        if (state_d == ST_CLEAR) begin
            presc_d = {PW{1'b0}};
        end else if (state_q == ST_RUN) begin
            if (tick_s) begin
                presc_d = {PW{1'b0}};
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else if (state_q == ST_PAUSE) begin
            presc_d = presc_q;
        end else begin
            presc_d = {PW{1'b0}};
        end

        // A dir toggle reaches DEC one cycle late so that a STEP on the same
        // edge still uses the old direction. A bounce flip reaches DEC at once.
        if (clr_press_s || (state_q == ST_CLEAR)) begin
            dir_d = 1'b1;
            dec_d = 1'b1;
        end else if (flip_s) begin
            dir_d = ~dir_q;
            dec_d = ~dir_q;
        end else if (dir_press_s) begin
            dir_d = ~dir_q;
            dec_d = dir_q;
        end else begin
            dir_d = dir_q;
            dec_d = dir_q;
        end

        // STEP follows a tick only if the sequencer is still running afterwards.
        step_d    = tick_s && (state_d == ST_RUN);
        clr_n_d   = (state_d != ST_CLEAR);
        run_led_d = (state_d == ST_RUN);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            presc_q   <= {PW{1'b0}};
            dir_q     <= 1'b1;
            step_q    <= 1'b0;
            dec_q     <= 1'b1;
            clr_n_q   <= 1'b1;
            run_led_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            dec_q     <= dec_d;
            clr_n_q   <= clr_n_d;
            run_led_q <= run_led_d;
        end
    end

    assign bus_if.step    = step_q;
    assign bus_if.dec     = dec_q;
    assign bus_if.clr_n   = clr_n_q;
    assign bus_if.run_led = run_led_q;

endmodule
